// File: rtl/fifo_client_pkg.sv
// Shared types and constants for the FIFO client: state encodings, op codes,
// the transfer-length limit and the length clamp helper.
package fifo_client_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  localparam logic OP_WRITE = 1'b0;
  localparam logic OP_READ  = 1'b1;
  localparam int   MAX_LEN  = 8;

  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    return (len > 4'(MAX_LEN)) ? 4'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/fifo_client_if.sv
// FIFO handshake bundle: enables and write data from the client, status flags,
// registered responses and read data from the FIFO.
interface fifo_client_if #(parameter int DATA_WIDTH = 32);

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;

  modport master (
    output wr_en, rd_en, din,
    input  full, empty, wr_ack, wr_err, rd_ack, rd_err, dout
  );

  modport slave (
    input  wr_en, rd_en, din,
    output full, empty, wr_ack, wr_err, rd_ack, rd_err, dout
  );

endinterface

// File: rtl/fifo_client_ns.sv
// Combinational next-state and strobe decode for the FIFO client FSM.
// Optional FIFO_CLIENT_PRECHECK_EN: hold in ISSUE while the target flag blocks.
//   state   | meaning
//   S_IDLE  | waiting for start
//   S_ISSUE | drive one enable
//   S_WAIT  | sample ack/err of previous enable
//   S_DONE  | one-cycle completion pulse
module fifo_client_ns
  import fifo_client_pkg::*;
(
  input  state_t     i_state,
  input  logic       i_start,
  input  logic [3:0] i_len,
  input  logic       i_op,
  input  logic [3:0] i_len_q,
  input  logic [3:0] i_xfer_cnt,
  input  logic       i_abort,
  input  logic       i_wr_ack,
  input  logic       i_wr_err,
  input  logic       i_rd_ack,
  input  logic       i_rd_err,
  input  logic       i_full,
  input  logic       i_empty,
  output state_t     o_next_state,
  output logic       o_issue,
  output logic       o_cnt_inc,
  output logic       o_set_err,
  output logic       o_rd_capture
);

  logic       w_ack;
  logic       w_nak;
  logic       w_blocked;
  logic [3:0] w_cnt_next;

  assign w_ack      = (i_op == OP_READ) ? i_rd_ack : i_wr_ack;
  assign w_nak      = (i_op == OP_READ) ? i_rd_err : i_wr_err;
  assign w_cnt_next = i_xfer_cnt + 4'd1;

`ifdef FIFO_CLIENT_PRECHECK_EN
  assign w_blocked = (i_op == OP_WRITE) ? i_full : i_empty;
`else
  logic w_unused_flags;
  assign w_unused_flags = i_full ^ i_empty;
  assign w_blocked      = 1'b0;
`endif

  always_comb begin
    o_next_state = i_state;
    o_issue      = 1'b0;
    o_cnt_inc    = 1'b0;
    o_set_err    = 1'b0;
    o_rd_capture = 1'b0;
    case (i_state)
      S_IDLE: begin
        if (i_start) o_next_state = (i_len == 4'd0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (i_abort) begin
          o_next_state = S_DONE;
          o_set_err    = 1'b1;
        end else if (!w_blocked) begin
          o_issue      = 1'b1;
          o_next_state = S_WAIT;
        end
      end
      S_WAIT: begin
        // err beats ack; silence is treated as an error too
        if (w_nak || !w_ack) begin
          o_set_err    = 1'b1;
          o_next_state = S_DONE;
        end else begin
          o_cnt_inc    = 1'b1;
          o_rd_capture = (i_op == OP_READ);
          o_set_err    = i_abort;
          o_next_state = (i_abort || (w_cnt_next == i_len_q)) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: o_next_state = S_IDLE;
      default: o_next_state = S_IDLE;
    endcase
  end

endmodule

// File: rtl/fifo_client.sv
// Command-driven master for the 8-entry FIFO: issues up to MAX_LEN single-beat
// transfers, one outstanding at a time. Optional macro: FIFO_CLIENT_PRECHECK_EN.
module fifo_client
  import fifo_client_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic                  i_op,
  input  logic [3:0]            i_len,
  input  logic [DATA_WIDTH-1:0] i_wr_seed,
  input  logic                  i_abort,
  fifo_client_if.master         fifo,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [3:0]            o_xfer_cnt,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid
);

  state_t                r_state;
  logic                  r_op;
  logic [3:0]            r_len;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [3:0]            r_xfer_cnt;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  state_t w_next_state;
  logic   w_issue;
  logic   w_cnt_inc;
  logic   w_set_err;
  logic   w_rd_capture;
  logic   w_accept;

  assign w_accept = (r_state == S_IDLE) && i_start;

  fifo_client_ns u_ns (
    .i_state      (r_state),
    .i_start      (i_start),
    .i_len        (i_len),
    .i_op         (r_op),
    .i_len_q      (r_len),
    .i_xfer_cnt   (r_xfer_cnt),
    .i_abort      (i_abort),
    .i_wr_ack     (fifo.wr_ack),
    .i_wr_err     (fifo.wr_err),
    .i_rd_ack     (fifo.rd_ack),
    .i_rd_err     (fifo.rd_err),
    .i_full       (fifo.full),
    .i_empty      (fifo.empty),
    .o_next_state (w_next_state),
    .o_issue      (w_issue),
    .o_cnt_inc    (w_cnt_inc),
    .o_set_err    (w_set_err),
    .o_rd_capture (w_rd_capture)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op   <= OP_WRITE;
      r_len  <= 4'd0;
      r_seed <= '0;
    end else if (w_accept) begin
      r_op   <= i_op;
      r_len  <= clamp_len(i_len);
      r_seed <= i_wr_seed;
    end
  end

  // count and err hold through IDLE; only an accepted start clears them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_xfer_cnt <= 4'd0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_xfer_cnt <= 4'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_cnt_inc) r_xfer_cnt <= r_xfer_cnt + 4'd1;
      if (w_set_err) r_err      <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_capture;
      if (w_rd_capture) r_rd_data <= fifo.dout;
    end
  end

  assign fifo.wr_en = w_issue && (r_op == OP_WRITE);
  assign fifo.rd_en = w_issue && (r_op == OP_READ);
  assign fifo.din   = ((r_state == S_ISSUE) && (r_op == OP_WRITE)) ?
                      (r_seed + DATA_WIDTH'(r_xfer_cnt)) : '0;

  assign o_busy     = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign o_done     = (r_state == S_DONE);
  assign o_err      = r_err;
  assign o_xfer_cnt = r_xfer_cnt;
  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_fifo_client.sv
// Bench for fifo_client: behavioural 8-entry FIFO responder plus a transaction
// level reference model of what each command should produce.
module tb_fifo_client;

  localparam int DW      = 32;
  localparam int MAX_CYC = 40;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_start = 1'b0;
  logic          i_op = 1'b0;
  logic [3:0]    i_len = 4'd0;
  logic [DW-1:0] i_wr_seed = '0;
  logic          i_abort = 1'b0;
  logic          o_busy, o_done, o_err, o_rd_valid;
  logic [3:0]    o_xfer_cnt;
  logic [DW-1:0] o_rd_data;

  fifo_client_if #(.DATA_WIDTH(DW)) fif ();

  fifo_client #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_start    (i_start),
    .i_op       (i_op),
    .i_len      (i_len),
    .i_wr_seed  (i_wr_seed),
    .i_abort    (i_abort),
    .fifo       (fif),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err),
    .o_xfer_cnt (o_xfer_cnt),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid)
  );

  always #5 clk = ~clk;

  // FIFO responder: registered ack/err one cycle after each enable
  logic [DW-1:0] fq[$];
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fif.wr_ack <= 1'b0; fif.wr_err <= 1'b0;
      fif.rd_ack <= 1'b0; fif.rd_err <= 1'b0;
      fif.dout   <= '0;
      fif.full   <= (fq.size() == 8);
      fif.empty  <= (fq.size() == 0);
    end else begin
      fif.wr_ack <= 1'b0; fif.wr_err <= 1'b0;
      fif.rd_ack <= 1'b0; fif.rd_err <= 1'b0;
      if (fif.wr_en) begin
        if (fq.size() < 8) begin fq.push_back(fif.din); fif.wr_ack <= 1'b1; end
        else fif.wr_err <= 1'b1;
      end
      if (fif.rd_en) begin
        if (fq.size() > 0) begin fif.dout <= fq.pop_front(); fif.rd_ack <= 1'b1; end
        else fif.rd_err <= 1'b1;
      end
      fif.full  <= (fq.size() == 8);
      fif.empty <= (fq.size() == 0);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  // observations of the last command
  int            en_cyc[$];
  logic [DW-1:0] din_seen[$];
  logic [DW-1:0] rd_seen[$];
  int            done_cyc;

  // reference model state and expectations
  logic [DW-1:0] mq[$];
  int            exp_en[$];
  logic [DW-1:0] exp_din[$];
  logic [DW-1:0] exp_rd[$];
  int            exp_done;
  int            exp_xfer;
  logic          exp_err;

  task automatic run_cmd(input logic op, input logic [3:0] len, input logic [DW-1:0] seed,
                         input int abort_cyc, input bit noise);
    en_cyc.delete(); din_seen.delete(); rd_seen.delete();
    done_cyc = -1;
    @(negedge clk);
    i_start = 1'b1; i_op = op; i_len = len; i_wr_seed = seed; i_abort = 1'b0;
    for (int c = 1; c <= MAX_CYC; c++) begin
      @(negedge clk);
      i_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        i_op = 1'($urandom); i_len = 4'($urandom); i_wr_seed = $urandom;
      end
      i_abort = (c == abort_cyc);
      #1;
      if (fif.wr_en || fif.rd_en) en_cyc.push_back(c);
      if (fif.wr_en) din_seen.push_back(fif.din);
      if (o_rd_valid) rd_seen.push_back(o_rd_data);
      if (o_done) begin
        done_cyc = c;
        break;
      end
    end
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    #1;
  endtask

  // Transaction-level expectation: each transfer costs two cycles; the FIFO
  // refuses a write when it holds 8 words and a read when it holds none.
  task automatic model_cmd(input logic op, input logic [3:0] len, input logic [DW-1:0] seed);
    int n;
    int att;
    n = (int'(len) > 8) ? 8 : int'(len);
    att = 0;
    exp_en.delete(); exp_din.delete(); exp_rd.delete();
    exp_xfer = 0; exp_err = 1'b0;
    for (int i = 0; i < n; i++) begin
      att++;
      exp_en.push_back(2 * i + 1);
      if (op == 1'b0) begin
        exp_din.push_back(seed + DW'(i));
        if (mq.size() < 8) begin mq.push_back(seed + DW'(i)); exp_xfer++; end
        else begin exp_err = 1'b1; break; end
      end else begin
        if (mq.size() > 0) begin exp_rd.push_back(mq.pop_front()); exp_xfer++; end
        else begin exp_err = 1'b1; break; end
      end
    end
    exp_done = 2 * att + 1;
  endtask

  task automatic flush_all();
    @(negedge clk);
    fq.delete(); mq.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({o_busy, o_done, o_err, o_rd_valid, fif.wr_en, fif.rd_en} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000",
               {o_busy, o_done, o_err, o_rd_valid, fif.wr_en, fif.rd_en});
    end
    n_checks++;
    if (o_xfer_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_xfer_cnt: got %0d want 0", o_xfer_cnt); end
    n_checks++;
    if (o_rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", o_rd_data); end
    n_checks++;
    if (fif.din !== '0) begin n_fail++; $display("FAIL reset_din: got %h want 0", fif.din); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_basic();
    int exp_c[3];
    exp_c = '{1, 3, 5};
    run_cmd(1'b0, 4'd3, 32'h10, 0, 1'b0);
    for (int i = 0; i < 3; i++) mq.push_back(32'h10 + DW'(i));
    n_checks++;
    if (en_cyc.size() != 3) begin n_fail++; $display("FAIL wr_basic_en_count: got %0d want 3", en_cyc.size()); end
    for (int i = 0; i < 3 && i < en_cyc.size(); i++) begin
      n_checks++;
      if (en_cyc[i] !== exp_c[i]) begin n_fail++; $display("FAIL wr_basic_en_cyc[%0d]: got %0d want %0d", i, en_cyc[i], exp_c[i]); end
      n_checks++;
      if (din_seen[i] !== 32'h10 + DW'(i)) begin n_fail++; $display("FAIL wr_basic_din[%0d]: got %h want %h", i, din_seen[i], 32'h10 + DW'(i)); end
    end
    n_checks++;
    if (done_cyc !== 7) begin n_fail++; $display("FAIL wr_basic_done: got %0d want 7", done_cyc); end
    n_checks++;
    if (o_xfer_cnt !== 4'd3) begin n_fail++; $display("FAIL wr_basic_xfer: got %0d want 3", o_xfer_cnt); end
    n_checks++;
    if (o_err !== 1'b0) begin n_fail++; $display("FAIL wr_basic_err: got %b want 0", o_err); end
  endtask

  task automatic test_read_basic();
    run_cmd(1'b1, 4'd3, 32'h0, 0, 1'b0);
    for (int i = 0; i < 3; i++) void'(mq.pop_front());
    n_checks++;
    if (rd_seen.size() != 3) begin n_fail++; $display("FAIL rd_basic_count: got %0d want 3", rd_seen.size()); end
    for (int i = 0; i < 3 && i < rd_seen.size(); i++) begin
      n_checks++;
      if (rd_seen[i] !== 32'h10 + DW'(i)) begin n_fail++; $display("FAIL rd_basic_data[%0d]: got %h want %h", i, rd_seen[i], 32'h10 + DW'(i)); end
    end
    n_checks++;
    if (done_cyc !== 7) begin n_fail++; $display("FAIL rd_basic_done: got %0d want 7", done_cyc); end
    n_checks++;
    if (o_err !== 1'b0) begin n_fail++; $display("FAIL rd_basic_err: got %b want 0", o_err); end
  endtask

  task automatic test_overfill();
    int abort_at;
    int exp_en_n;
    flush_all();
    run_cmd(1'b0, 4'd3, 32'hA0, 0, 1'b0);
`ifdef FIFO_CLIENT_PRECHECK_EN
    abort_at = 12;
    exp_en_n = 5;
`else
    abort_at = 0;
    exp_en_n = 6;
`endif
    run_cmd(1'b0, 4'd8, 32'hB0, abort_at, 1'b0);
    n_checks++;
    if (en_cyc.size() != exp_en_n) begin n_fail++; $display("FAIL overfill_en_count: got %0d want %0d", en_cyc.size(), exp_en_n); end
    n_checks++;
    if (o_xfer_cnt !== 4'd5) begin n_fail++; $display("FAIL overfill_xfer: got %0d want 5", o_xfer_cnt); end
    n_checks++;
    if (o_err !== 1'b1) begin n_fail++; $display("FAIL overfill_err: got %b want 1", o_err); end
    n_checks++;
    if (done_cyc !== 13) begin n_fail++; $display("FAIL overfill_done: got %0d want 13", done_cyc); end
  endtask

  task automatic test_noop();
    run_cmd(1'b0, 4'd0, 32'h33, 0, 1'b0);
    n_checks++;
    if (done_cyc !== 1) begin n_fail++; $display("FAIL noop_done: got %0d want 1", done_cyc); end
    n_checks++;
    if (en_cyc.size() != 0) begin n_fail++; $display("FAIL noop_en_count: got %0d want 0", en_cyc.size()); end
    n_checks++;
    if (o_xfer_cnt !== 4'd0 || o_err !== 1'b0) begin n_fail++; $display("FAIL noop_status: got xfer %0d err %b want 0 0", o_xfer_cnt, o_err); end
  endtask

  task automatic test_clamp();
    flush_all();
    run_cmd(1'b0, 4'd15, 32'h100, 0, 1'b0);
    for (int i = 0; i < 8; i++) mq.push_back(32'h100 + DW'(i));
    n_checks++;
    if (en_cyc.size() != 8) begin n_fail++; $display("FAIL clamp_en_count: got %0d want 8", en_cyc.size()); end
    n_checks++;
    if (din_seen.size() == 8 && din_seen[7] !== 32'h107) begin n_fail++; $display("FAIL clamp_last_din: got %h want 107", din_seen[7]); end
    n_checks++;
    if (done_cyc !== 17) begin n_fail++; $display("FAIL clamp_done: got %0d want 17", done_cyc); end
    n_checks++;
    if (o_xfer_cnt !== 4'd8 || o_err !== 1'b0) begin n_fail++; $display("FAIL clamp_status: got xfer %0d err %b want 8 0", o_xfer_cnt, o_err); end
  endtask

  task automatic test_abort_wait();
    run_cmd(1'b1, 4'd4, 32'h0, 2, 1'b0);
    void'(mq.pop_front());
    n_checks++;
    if (o_xfer_cnt !== 4'd1) begin n_fail++; $display("FAIL abort_xfer: got %0d want 1", o_xfer_cnt); end
    n_checks++;
    if (o_err !== 1'b1) begin n_fail++; $display("FAIL abort_err: got %b want 1", o_err); end
    n_checks++;
    if (done_cyc !== 3) begin n_fail++; $display("FAIL abort_done: got %0d want 3", done_cyc); end
    n_checks++;
    if (rd_seen.size() != 1 || rd_seen[0] !== 32'h100) begin n_fail++; $display("FAIL abort_rd: got %0d words want 1 word 100", rd_seen.size()); end
    n_checks++;
    if (en_cyc.size() != 1) begin n_fail++; $display("FAIL abort_en_count: got %0d want 1", en_cyc.size()); end
  endtask

  task automatic test_reset_mid();
    flush_all();
    i_start = 1'b1; i_op = 1'b0; i_len = 4'd3; i_wr_seed = 32'h55;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    mq.push_back(32'h55);
    n_checks++;
    if ({o_busy, o_done, o_err, o_rd_valid, fif.wr_en, fif.rd_en} !== 6'b0) begin
      n_fail++;
      $display("FAIL midreset_flags: got %b want 000000",
               {o_busy, o_done, o_err, o_rd_valid, fif.wr_en, fif.rd_en});
    end
    n_checks++;
    if (o_rd_data !== '0 || o_xfer_cnt !== 4'd0 || fif.din !== '0) begin
      n_fail++;
      $display("FAIL midreset_values: got rd_data %h xfer %0d din %h want 0 0 0", o_rd_data, o_xfer_cnt, fif.din);
    end
    @(negedge clk);
    reset_n = 1'b1;
    run_cmd(1'b0, 4'd1, 32'h77, 0, 1'b0);
    mq.push_back(32'h77);
    n_checks++;
    if (done_cyc !== 3 || o_xfer_cnt !== 4'd1 || o_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_after: got done %0d xfer %0d err %b want 3 1 0", done_cyc, o_xfer_cnt, o_err);
    end
    n_checks++;
    if (din_seen.size() != 1 || din_seen[0] !== 32'h77) begin n_fail++; $display("FAIL midreset_din: got %0d words want one word 77", din_seen.size()); end
  endtask

  task automatic test_random();
    logic          op;
    logic [3:0]    len;
    logic [DW-1:0] seed;
    flush_all();
    for (int it = 0; it < 24; it++) begin
      op   = 1'($urandom);
      len  = 4'($urandom_range(0, 15));
      seed = $urandom;
`ifdef FIFO_CLIENT_PRECHECK_EN
      len = (op == 1'b0) ? 4'($urandom_range(0, 8 - mq.size())) : 4'($urandom_range(0, mq.size()));
`endif
      model_cmd(op, len, seed);
      run_cmd(op, len, seed, 0, 1'b1);
      n_checks++;
      if (done_cyc !== exp_done) begin n_fail++; $display("FAIL rand%0d_done: got %0d want %0d", it, done_cyc, exp_done); end
      n_checks++;
      if (o_xfer_cnt !== 4'(exp_xfer)) begin n_fail++; $display("FAIL rand%0d_xfer: got %0d want %0d", it, o_xfer_cnt, exp_xfer); end
      n_checks++;
      if (o_err !== exp_err) begin n_fail++; $display("FAIL rand%0d_err: got %b want %b", it, o_err, exp_err); end
      n_checks++;
      if (en_cyc.size() != exp_en.size()) begin n_fail++; $display("FAIL rand%0d_en_count: got %0d want %0d", it, en_cyc.size(), exp_en.size()); end
      for (int i = 0; i < en_cyc.size() && i < exp_en.size(); i++) begin
        n_checks++;
        if (en_cyc[i] !== exp_en[i]) begin n_fail++; $display("FAIL rand%0d_en_cyc[%0d]: got %0d want %0d", it, i, en_cyc[i], exp_en[i]); end
      end
      n_checks++;
      if (din_seen.size() != exp_din.size() || rd_seen.size() != exp_rd.size()) begin
        n_fail++;
        $display("FAIL rand%0d_data_count: got din %0d rd %0d want din %0d rd %0d",
                 it, din_seen.size(), rd_seen.size(), exp_din.size(), exp_rd.size());
      end
      for (int i = 0; i < din_seen.size() && i < exp_din.size(); i++) begin
        n_checks++;
        if (din_seen[i] !== exp_din[i]) begin n_fail++; $display("FAIL rand%0d_din[%0d]: got %h want %h", it, i, din_seen[i], exp_din[i]); end
      end
      for (int i = 0; i < rd_seen.size() && i < exp_rd.size(); i++) begin
        n_checks++;
        if (rd_seen[i] !== exp_rd[i]) begin n_fail++; $display("FAIL rand%0d_rd[%0d]: got %h want %h", it, i, rd_seen[i], exp_rd[i]); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_overfill();
    test_noop();
    test_clamp();
    test_abort_wait();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
